// File: rtl/adc_tone_burst_gen.sv
// Tone-burst generator: bursts of LUT sine samples on NUM_CH harmonic channels, separated by idle gaps.
// Latency: first sample registered and visible the cycle after an accepted start; one sample per transfer.
// Backpressure: out_ready=0 freezes data/sop/eop and the phase accumulators; abort/rst drop the run at once.
//
// Ports:
//   clk, rst              sample clock, asynchronous active-high reset
//   start, abort          run request (IDLE only) / immediate stop
//   freq_word, offset_bin phase increment and output format, latched on accepted start
//   out_valid/out_ready   sample handshake; out_data carries channel c in [c*ADC_WIDTH +: ADC_WIDTH]
//   out_sop, out_eop      first / last sample of a burst
//   busy, done            run in progress / one-cycle pulse after the final burst
module adc_tone_burst_gen #(
   parameter int ADC_WIDTH   = 14,
   parameter int NUM_CH      = 1,
   parameter int PHASE_WIDTH = 24,
   parameter int LUT_ADDR_W  = 8,
   parameter int LARGO_TONO  = 500,
   parameter int GAP_LEN     = 16,
   parameter int SIM_PKT_NUM = 10
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start,
   input  logic                        abort,
   input  logic [PHASE_WIDTH-1:0]      freq_word,
   input  logic                        offset_bin,
   input  logic                        out_ready,
   output logic                        out_valid,
   output logic [NUM_CH*ADC_WIDTH-1:0] out_data,
   output logic                        out_sop,
   output logic                        out_eop,
   output logic                        busy,
   output logic                        done
);

   localparam int LUT_DEPTH = 2 ** LUT_ADDR_W;
   localparam int SCW = (LARGO_TONO > 1) ? $clog2(LARGO_TONO) : 1;
   localparam int GCW = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;
   // Continuous mode only needs a free-running counter that wraps silently.
   localparam int BCW = (SIM_PKT_NUM > 0) ? $clog2(SIM_PKT_NUM + 1) : 16;
   localparam logic [SCW-1:0] LAST_SAMPLE = SCW'(LARGO_TONO - 1);
   localparam logic [GCW-1:0] LAST_GAP    = GCW'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);
   localparam logic [BCW-1:0] PKT_TARGET  = BCW'(SIM_PKT_NUM);
   localparam logic           ONE_SAMPLE  = (LARGO_TONO == 1);

   typedef enum logic [1:0] {S_IDLE, S_TONE, S_GAP} state_t;

   // Full-wave sine entry, rounded half away from zero, full-scale minus one.
   function automatic logic [ADC_WIDTH-1:0] sine_entry(input int k);
      real amp;
      real ang;
      real s;
      int  r;
      amp = real'((2 ** (ADC_WIDTH - 1)) - 1);
      ang = 2.0 * 3.14159265358979323846 * real'(k) / real'(LUT_DEPTH);
      s   = amp * $sin(ang);
      r   = (s >= 0.0) ? $rtoi(s + 0.5) : -$rtoi(0.5 - s);
      return r[ADC_WIDTH-1:0];
   endfunction

   // Offset binary is two's complement with the sign bit inverted.
   function automatic logic [ADC_WIDTH-1:0] fmt(input logic [ADC_WIDTH-1:0] s, input logic ob);
      return {s[ADC_WIDTH-1] ^ ob, s[ADC_WIDTH-2:0]};
   endfunction

   logic [ADC_WIDTH-1:0] lut [LUT_DEPTH];

   for (genvar k = 0; k < LUT_DEPTH; k++) begin : g_lut
      assign lut[k] = sine_entry(k);
   end

   state_t                      state;
   logic [PHASE_WIDTH-1:0]      inc_q   [NUM_CH];
   logic [PHASE_WIDTH-1:0]      phase_q [NUM_CH];
   logic [PHASE_WIDTH-1:0]      phase_nxt [NUM_CH];
   logic                        ofs_q;
   logic [SCW-1:0]              sample_cnt;
   logic [GCW-1:0]              gap_cnt;
   logic [BCW-1:0]              burst_cnt;
   logic [BCW-1:0]              burst_nxt;
   logic [NUM_CH*ADC_WIDTH-1:0] data_nxt;
   logic [NUM_CH*ADC_WIDTH-1:0] data_first_in;
   logic [NUM_CH*ADC_WIDTH-1:0] data_first_q;
   logic                        xfer;

   // phase_q holds the phase of the sample currently on out_data, so the
   // next sample is looked up from the advanced phase.
   always_comb begin
      data_nxt = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         phase_nxt[c] = phase_q[c] + inc_q[c];
         data_nxt[c*ADC_WIDTH +: ADC_WIDTH] =
            fmt(lut[phase_nxt[c][PHASE_WIDTH-1 -: LUT_ADDR_W]], ofs_q);
      end
   end

   // Every burst starts at phase 0 on all channels.
   assign data_first_in = {NUM_CH{fmt(lut[0], offset_bin)}};
   assign data_first_q  = {NUM_CH{fmt(lut[0], ofs_q)}};
   assign burst_nxt     = burst_cnt + 1'b1;
   assign xfer          = (state == S_TONE) && out_valid && out_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         ofs_q      <= 1'b0;
         sample_cnt <= '0;
         gap_cnt    <= '0;
         burst_cnt  <= '0;
         out_valid  <= 1'b0;
         out_data   <= '0;
         out_sop    <= 1'b0;
         out_eop    <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         for (int c = 0; c < NUM_CH; c++) begin
            inc_q[c]   <= '0;
            phase_q[c] <= '0;
         end
      end else begin
         done <= 1'b0;
         if (abort) begin
            // abort beats transfer, eop and gap expiry; start+abort in IDLE stays IDLE
            state     <= S_IDLE;
            out_valid <= 1'b0;
            out_sop   <= 1'b0;
            out_eop   <= 1'b0;
            busy      <= 1'b0;
         end else begin
            case (state)
               S_IDLE: begin
                  if (start) begin
                     for (int c = 0; c < NUM_CH; c++) begin
                        inc_q[c]   <= PHASE_WIDTH'(freq_word * PHASE_WIDTH'(c + 1));
                        phase_q[c] <= '0;
                     end
                     ofs_q      <= offset_bin;
                     sample_cnt <= '0;
                     gap_cnt    <= '0;
                     burst_cnt  <= '0;
                     out_data   <= data_first_in;
                     out_valid  <= 1'b1;
                     out_sop    <= 1'b1;
                     out_eop    <= ONE_SAMPLE;
                     busy       <= 1'b1;
                     state      <= S_TONE;
                  end
               end

               S_TONE: begin
                  if (xfer) begin
                     if (out_eop) begin
                        burst_cnt <= burst_nxt;
                        if ((SIM_PKT_NUM != 0) && (burst_nxt == PKT_TARGET)) begin
                           state     <= S_IDLE;
                           out_valid <= 1'b0;
                           out_sop   <= 1'b0;
                           out_eop   <= 1'b0;
                           busy      <= 1'b0;
                           done      <= 1'b1;
                        end else if (GAP_LEN == 0) begin
                           for (int c = 0; c < NUM_CH; c++) phase_q[c] <= '0;
                           sample_cnt <= '0;
                           out_data   <= data_first_q;
                           out_sop    <= 1'b1;
                           out_eop    <= ONE_SAMPLE;
                        end else begin
                           state     <= S_GAP;
                           gap_cnt   <= '0;
                           out_valid <= 1'b0;
                           out_sop   <= 1'b0;
                           out_eop   <= 1'b0;
                        end
                     end else begin
                        for (int c = 0; c < NUM_CH; c++) phase_q[c] <= phase_nxt[c];
                        out_data   <= data_nxt;
                        sample_cnt <= sample_cnt + 1'b1;
                        out_sop    <= 1'b0;
                        out_eop    <= ((sample_cnt + 1'b1) == LAST_SAMPLE);
                     end
                  end
               end

               S_GAP: begin
                  if (gap_cnt == LAST_GAP) begin
                     for (int c = 0; c < NUM_CH; c++) phase_q[c] <= '0;
                     sample_cnt <= '0;
                     out_data   <= data_first_q;
                     out_valid  <= 1'b1;
                     out_sop    <= 1'b1;
                     out_eop    <= ONE_SAMPLE;
                     state      <= S_TONE;
                  end else begin
                     gap_cnt <= gap_cnt + 1'b1;
                  end
               end

               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule
